commit_credit_arb: RTL and testbench

//  Round-robin arbiter sharing the NGRANT write ports of one commit-lane FIFO among NREQ execute-side requesters.

---
 rtl/commit_credit_arb.sv | 112 +++++++++++
 tb/tb_commit_credit_arb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/commit_credit_arb.sv
// Round-robin, credit-gated arbiter feeding NGRANT write ports of one commit-lane FIFO.
// Optional COMMIT_ARB_PERF_EN adds a 32-bit stall counter output (perf_stall_cnt).
module commit_credit_arb #(
  parameter int NREQ   = 8,
  parameter int NGRANT = 2,
  parameter int QLEN   = 32,
  parameter int DW     = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ-1:0][DW-1:0]       req_data,
  output logic [NREQ-1:0]               req_ready,
  output logic [NGRANT-1:0]             wr_valid,
  output logic [NGRANT-1:0][DW-1:0]     wr_data,
  input  logic                          deq,
  output logic [$clog2(QLEN):0]         credits,
  output logic                          full
`ifdef COMMIT_ARB_PERF_EN
  ,
  output logic [31:0]                   perf_stall_cnt
`endif
);

  localparam int CW  = $clog2(QLEN) + 1;
  localparam int CW1 = CW + 1;
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW  = $clog2(NGRANT + 1);

  // Handshake: a payload transfers in the cycle where req_valid[i] & req_ready[i]
  // are both high; req_ready depends only on req_valid, credits and rr_ptr.

  logic [PW-1:0]             rr_ptr;
  logic [NREQ-1:0]           grant;
  logic [NGRANT-1:0][PW-1:0] sel;
  logic [GW-1:0]             ngrant;
  logic [PW-1:0]             last;
  logic [CW1-1:0]            cred_sum;
  logic [CW-1:0]             credits_nxt;
  logic [PW-1:0]             rr_nxt;

  always_comb begin
    int cnt;
    int idx;
    int limit;
    grant  = '0;
    sel    = '0;
    last   = '0;
    cnt    = 0;
    idx    = 0;
    limit  = (int'(credits) < NGRANT) ? int'(credits) : NGRANT;
    for (int j = 0; j < NREQ; j++) begin
      idx = int'(rr_ptr) + j;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx] && (cnt < limit)) begin
        grant[idx] = 1'b1;
        for (int k = 0; k < NGRANT; k++) begin
          if (k == cnt) sel[k] = PW'(idx);
        end
        last = PW'(idx);
        cnt  = cnt + 1;
      end
    end
    ngrant = GW'(cnt);
  end

  assign req_ready = reset ? grant : '0;
  assign full      = (credits == '0);

  // A deq at full credit is illegal; clamp so the count can never exceed QLEN.
  assign cred_sum    = {1'b0, credits} - CW1'(ngrant) + CW1'(deq);
  assign credits_nxt = (cred_sum > CW1'(QLEN)) ? CW'(QLEN) : cred_sum[CW-1:0];
  assign rr_nxt      = (last == PW'(NREQ - 1)) ? '0 : last + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      credits  <= CW'(QLEN);
      rr_ptr   <= '0;
      wr_valid <= '0;
    end else begin
      credits <= credits_nxt;
      if (ngrant != '0) rr_ptr <= rr_nxt;
      for (int k = 0; k < NGRANT; k++) begin
        wr_valid[k] <= (k < int'(ngrant));
      end
    end
  end

  // Payload has no reset; it is only meaningful where wr_valid is set.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NGRANT; k++) begin
      wr_data[k] <= req_data[sel[k]];
    end
  end

`ifdef COMMIT_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
    end else if ((|req_valid) && (credits == '0)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  deq_at_full_credit : assert property (@(posedge clk) disable iff (!reset)
    !(deq && (credits == CW'(QLEN))))
    else $error("deq while credits == QLEN");
`endif

endmodule

// File: tb/tb_commit_credit_arb.sv
// Directed, table-driven bench for commit_credit_arb (NREQ=8, NGRANT=2, QLEN=32).
module tb_commit_credit_arb;
  localparam int NREQ   = 8;
  localparam int NGRANT = 2;
  localparam int QLEN   = 32;
  localparam int DW     = 64;

  logic                      clk;
  logic                      reset;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0][DW-1:0]   req_data;
  logic [NREQ-1:0]           req_ready;
  logic [NGRANT-1:0]         wr_valid;
  logic [NGRANT-1:0][DW-1:0] wr_data;
  logic                      deq;
  logic [5:0]                credits;
  logic                      full;
`ifdef COMMIT_ARB_PERF_EN
  logic [31:0]               perf_stall_cnt;
`endif

  commit_credit_arb #(.NREQ(NREQ), .NGRANT(NGRANT), .QLEN(QLEN), .DW(DW)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .wr_valid(wr_valid),
    .wr_data(wr_data),
    .deq(deq),
    .credits(credits),
    .full(full)
`ifdef COMMIT_ARB_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] valid;
    logic       deq;
    logic [7:0] ready;
    logic [5:0] cred;
    logic [1:0] wrv;
    int         p0;
    int         p1;
  } vec_t;

  vec_t          tbl[$];
  logic [DW-1:0] exp_q[$];
  int            checks;
  int            failures;

  function automatic logic [DW-1:0] data_of(input int req, input int step);
    return {16'hC0DE, 16'(step), 16'hBEEF, 16'(req)};
  endfunction

  function automatic vec_t mk(input logic [7:0] valid, input logic d, input logic [7:0] ready,
                              input logic [5:0] cred, input logic [1:0] wrv,
                              input int p0, input int p1);
    vec_t v;
    v.valid = valid; v.deq = d; v.ready = ready; v.cred = cred;
    v.wrv = wrv; v.p0 = p0; v.p1 = p1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] valid, input logic d, input int step);
    req_valid = valid;
    deq       = d;
    for (int i = 0; i < NREQ; i++) req_data[i] = data_of(i, step);
  endtask

  task automatic check_ports(input logic [1:0] wrv);
    check("wr_valid", 64'(wr_valid), 64'(wrv));
    for (int k = 0; k < NGRANT; k++) begin
      if (wr_valid[k]) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL wr_data%0d: got %0h with no expected payload", k, wr_data[k]);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (wr_data[k] !== e) begin
            failures++;
            $display("FAIL wr_data%0d: got %0h expected %0h", k, wr_data[k], e);
          end
        end
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int step);
    drive(v.valid, v.deq, step);
    #1;
    check("req_ready", 64'(req_ready), 64'(v.ready));
    check("credits", 64'(credits), 64'(v.cred));
    check("full", 64'(full), 64'(v.cred == 6'd0));
    if (v.wrv[0]) exp_q.push_back(data_of(v.p0, step));
    if (v.wrv[1]) exp_q.push_back(data_of(v.p1, step));
    @(posedge clk);
    #1;
    check_ports(v.wrv);
  endtask

  initial begin
    int step;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    drive(8'hFF, 1'b0, 0);

    // reset state, with requests pending
    @(posedge clk); @(posedge clk); #1;
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_credits", 64'(credits), 64'd32);
    check("rst_full", 64'(full), 64'd0);
    check("rst_wr_valid", 64'(wr_valid), 64'h0);
    reset = 1'b1;

    // fill: all valid, pairs granted in index order, credits drop by 2
    for (int k = 0; k < 16; k++)
      tbl.push_back(mk(8'hFF, 1'b0, 8'b11 << (2 * (k % 4)), 6'(32 - 2 * k), 2'b11,
                       2 * (k % 4), 2 * (k % 4) + 1));
    tbl.push_back(mk(8'hFF,       1'b1, 8'h00,       6'd0, 2'b00, 0, 0)); // full: deq gives no grant
    tbl.push_back(mk(8'hFF,       1'b0, 8'h01,       6'd1, 2'b01, 0, 0)); // one credit -> one grant
    tbl.push_back(mk(8'h00,       1'b1, 8'h00,       6'd0, 2'b00, 0, 0));
    tbl.push_back(mk(8'b0110_0000, 1'b0, 8'b0010_0000, 6'd1, 2'b01, 5, 0)); // only req5
    tbl.push_back(mk(8'h00,       1'b1, 8'h00,       6'd0, 2'b00, 0, 0));
    tbl.push_back(mk(8'h00,       1'b1, 8'h00,       6'd1, 2'b00, 0, 0));
    tbl.push_back(mk(8'b0100_0000, 1'b1, 8'b0100_0000, 6'd2, 2'b01, 6, 0)); // grant + deq same cycle
    tbl.push_back(mk(8'b1000_0001, 1'b0, 8'b1000_0001, 6'd2, 2'b11, 7, 0)); // wrap: 7 then 0
    tbl.push_back(mk(8'hFF,       1'b1, 8'h00,       6'd0, 2'b00, 0, 0));
    tbl.push_back(mk(8'b0000_0011, 1'b0, 8'b0000_0010, 6'd1, 2'b01, 1, 0)); // rr_ptr is 1
    tbl.push_back(mk(8'h00,       1'b1, 8'h00,       6'd0, 2'b00, 0, 0));
    tbl.push_back(mk(8'h00,       1'b1, 8'h00,       6'd1, 2'b00, 0, 0));
    tbl.push_back(mk(8'h00,       1'b1, 8'h00,       6'd2, 2'b00, 0, 0));
    tbl.push_back(mk(8'hFF,       1'b0, 8'b0000_1100, 6'd3, 2'b11, 2, 3));
    tbl.push_back(mk(8'hFF,       1'b0, 8'b0001_0000, 6'd1, 2'b01, 4, 0));

    step = 1;
    foreach (tbl[i]) begin
      run_vec(tbl[i], step);
      step++;
    end

`ifdef COMMIT_ARB_PERF_EN
    begin
      logic [31:0] base;
      base = perf_stall_cnt;
      for (int c = 0; c < 10; c++) begin
        drive(8'hFF, 1'b0, step);
        @(posedge clk); #1;
      end
      check("perf_stall_cnt", 64'(perf_stall_cnt - base), 64'd10);
    end
`endif

    // reset mid-stream with both ports about to fire
    run_vec(mk(8'h00, 1'b1, 8'h00, 6'd0, 2'b00, 0, 0), step); step++;
    run_vec(mk(8'h00, 1'b1, 8'h00, 6'd1, 2'b00, 0, 0), step); step++;
    drive(8'hFF, 1'b0, step);
    #1;
    check("mid_ready", 64'(req_ready), 64'b0110_0000);
    @(posedge clk); #1;
    check("mid_wr_valid", 64'(wr_valid), 64'b11);
    reset = 1'b0;
    drive(8'hFF, 1'b0, step + 1);
    #1;
    check("rst_low_ready", 64'(req_ready), 64'h0);
    @(posedge clk); #1;
    check("rst_drop_wr_valid", 64'(wr_valid), 64'h0);
    check("rst_credits2", 64'(credits), 64'd32);
    check("rst_low_ready2", 64'(req_ready), 64'h0);
    @(posedge clk); #1;
    check("rst_hold_wr_valid", 64'(wr_valid), 64'h0);
    reset = 1'b1;
    step  = step + 2;
    run_vec(mk(8'hFF, 1'b0, 8'h03, 6'd32, 2'b11, 0, 1), step); // rr_ptr back to 0

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard bound on run time
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
